// File: rtl/sprite_draw_if.sv
// Row-fetch port between the sprite drawer (master) and a synchronous bitmap ROM.
// rom_data follows rom_addr by one clock; its MSB is the leftmost pixel.
interface sprite_draw_if #(
    parameter int ADDRW = 3,
    parameter int WIDTH = 8
);
    logic [ADDRW-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_draw.sv
// Draws one scaled monochrome bitmap sprite into the 480p pixel stream.
// A bitmap row is fetched during horizontal blanking, then shifted out from sx==xl.
module sprite_draw #(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int SCALE  = 2,
    parameter int ADDRW  = $clog2(HEIGHT)
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    sprite_draw_if.master           rom,
    output logic                    pix,
    output logic                    drawing
);
    localparam int HW = $clog2(WIDTH*SCALE+1);
    localparam int VW = $clog2(HEIGHT*SCALE+1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(WIDTH-1);
    localparam logic [HW-1:0] HSC_LAST  = HW'(SCALE-1);
    localparam logic [VW-1:0] ROW_LAST  = VW'(HEIGHT-1);
    localparam logic [VW-1:0] VSC_LAST  = VW'(SCALE-1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, WAIT_X, DRAW} state_e;

    state_e                  state_q, state_d;
    logic signed [CORDW-1:0] xl_q, xl_d, yl_q, yl_d;
    logic [VW-1:0]           row_q, row_d, vsc_q, vsc_d;
    logic [HW-1:0]           hcnt_q, hcnt_d, hsc_q, hsc_d;
    logic [WIDTH-1:0]        shreg_q, shreg_d;
    logic                    started_q, started_d, done_q, done_d;
    logic [ADDRW-1:0]        rom_addr_q, rom_addr_d;
    logic                    pix_q, pix_d, drawing_q, drawing_d;
    logic                    line_act;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            xl_q       <= '0;
            yl_q       <= '0;
            row_q      <= '0;
            vsc_q      <= '0;
            hcnt_q     <= '0;
            hsc_q      <= '0;
            shreg_q    <= '0;
            started_q  <= 1'b0;
            done_q     <= 1'b1;
            rom_addr_q <= '0;
            pix_q      <= 1'b0;
            drawing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xl_q       <= xl_d;
            yl_q       <= yl_d;
            row_q      <= row_d;
            vsc_q      <= vsc_d;
            hcnt_q     <= hcnt_d;
            hsc_q      <= hsc_d;
            shreg_q    <= shreg_d;
            started_q  <= started_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
            pix_q      <= pix_d;
            drawing_q  <= drawing_d;
        end
    end

    // Vertical tracking: the row/scale counters stand in for (sy-yl)/SCALE.
    always_comb begin
        xl_d      = xl_q;
        yl_d      = yl_q;
        row_d     = row_q;
        vsc_d     = vsc_q;
        started_d = started_q;
        done_d    = done_q;
        line_act  = 1'b0;
        if (frame) begin
            xl_d      = sprx;
            yl_d      = spry;
            row_d     = '0;
            vsc_d     = '0;
            started_d = 1'b0;
            done_d    = 1'b0;
        end
        if (line && !done_d) begin
            if (!started_d) begin
                if (sy == yl_d) begin
                    started_d = 1'b1;
                    row_d     = '0;
                    vsc_d     = '0;
                    line_act  = 1'b1;
                end
            end else if (row_d == ROW_LAST && vsc_d == VSC_LAST) begin
                done_d = 1'b1;
            end else begin
                line_act = 1'b1;
                if (vsc_d == VSC_LAST) begin
                    vsc_d = '0;
                    row_d = row_d + 1'b1;
                end else begin
                    vsc_d = vsc_d + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        hsc_d      = hsc_q;
        shreg_d    = shreg_q;
        rom_addr_d = rom_addr_q;
        pix_d      = pix_q;
        drawing_d  = drawing_q;
        // A frame also aborts, so an unreachable xl can never match in vertical blanking.
        if (frame || line) begin
            state_d   = IDLE;
            drawing_d = 1'b0;
            pix_d     = 1'b0;
            if (line_act) begin
                state_d    = FETCH;
                rom_addr_d = row_d[ADDRW-1:0];
            end
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                FETCH: state_d = LATCH;
                LATCH: begin
                    shreg_d = rom.rom_data;
                    hcnt_d  = '0;
                    hsc_d   = '0;
                    state_d = WAIT_X;
                end
                WAIT_X: begin
                    if (sx == xl_q) begin
                        state_d   = DRAW;
                        drawing_d = 1'b1;
                        pix_d     = shreg_q[WIDTH-1];
                    end
                end
                DRAW: begin
                    // hcnt/hsc name the pixel already on the output; this cycle picks the next.
                    if (hsc_q == HSC_LAST) begin
                        hsc_d   = '0;
                        hcnt_d  = hcnt_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end else begin
                        hsc_d = hsc_q + 1'b1;
                    end
                    if (hsc_q == HSC_LAST && hcnt_q == HCNT_LAST) begin
                        state_d   = IDLE;
                        drawing_d = 1'b0;
                        pix_d     = 1'b0;
                    end else begin
                        pix_d = shreg_d[WIDTH-1];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign pix          = pix_q;
    assign drawing      = drawing_q;
endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: shortened line timing (sx from -20) with hand-computed
// expected spans, scaled row patterns and ROM addresses.
module tb_sprite_draw;
    localparam int H_STA    = -20;
    localparam int LINE_LEN = 260;
    localparam int V_STA    = -5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame = 1'b0, line = 1'b0;
    logic signed [15:0] sx = '0, sy = '0, sprx = '0, spry = '0;
    logic pix, drawing;
    logic [7:0] rom_mem [8];
    logic [15:0] exp_mask [8];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_draw_if #(.ADDRW(3), .WIDTH(8)) rom_if ();

    always_ff @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

    sprite_draw #(.CORDW(16), .WIDTH(8), .HEIGHT(8), .SCALE(2)) dut (
        .clk_pix(clk), .rst_n(rst_n), .frame(frame), .line(line),
        .sx(sx), .sy(sy), .sprx(sprx), .spry(spry),
        .rom(rom_if.master), .pix(pix), .drawing(drawing)
    );

    task automatic do_frame(input int x, input int y);
        sprx = 16'(x); spry = 16'(y);
        frame = 1'b1; sx = 16'(H_STA); sy = 16'(V_STA);
        @(posedge clk); #1;
        frame = 1'b0;
    endtask

    // Runs one line of len cycles and summarises what the outputs did.
    task automatic do_line(input int y, input int len, input bit fr, output int nd,
                           output int first, output int last, output logic [15:0] pm,
                           output logic [2:0] addr, output logic d0, output int stray);
        nd = 0; first = -999; last = -999; pm = '0; addr = '0; d0 = 1'b0; stray = 0;
        for (int i = 0; i < len; i++) begin
            sx = 16'(H_STA + i); sy = 16'(y);
            line = (i == 0); frame = fr && (i == 0);
            @(posedge clk); #1;
            if (i == 0) begin
                d0 = drawing;
                addr = rom_if.rom_addr;
            end
            if (drawing) begin
                if (nd == 0) first = H_STA + i;
                last = H_STA + i;
                if (nd < 16) pm[15-nd] = pix;
                nd++;
            end else if (pix) begin
                stray++;
            end
        end
        line = 1'b0; frame = 1'b0;
    endtask

    task automatic test_reset();
        int nd, first, last, stray; logic [15:0] pm; logic [2:0] ad; logic d0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (drawing !== 1'b0) begin errors++; $display("FAIL reset_drawing: got %b want 0", drawing); end
        checks++; if (pix !== 1'b0) begin errors++; $display("FAIL reset_pix: got %b want 0", pix); end
        checks++; if (rom_if.rom_addr !== 3'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_if.rom_addr); end
        rst_n = 1'b1;
        // Done flag is set out of reset, so a line at sy==yl==0 draws nothing.
        do_line(0, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 0) begin errors++; $display("FAIL reset_no_draw: got %0d cycles want 0", nd); end
    endtask

    task automatic test_rows();
        int nd, first, last, stray; logic [15:0] pm; logic [2:0] ad; logic d0;
        do_frame(100, 50);
        do_line(49, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 0) begin errors++; $display("FAIL above_sprite: got %0d cycles want 0", nd); end
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 16) begin errors++; $display("FAIL basic_len: got %0d want 16", nd); end
        checks++; if (first !== 100 || last !== 115) begin errors++; $display("FAIL basic_span: got %0d..%0d want 100..115", first, last); end
        checks++; if (pm !== 16'hC003) begin errors++; $display("FAIL basic_pix: got %h want c003", pm); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL basic_stray: got %0d want 0", stray); end
        for (int y = 51; y <= 65; y++) begin
            do_line(y, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
            checks++;
            if (ad !== 3'((y - 50) / 2) || nd !== 16 || first !== 100 || pm !== exp_mask[(y-50)/2]) begin
                errors++;
                $display("FAIL row_map y=%0d: addr=%0d n=%0d x0=%0d pix=%h want addr=%0d n=16 x0=100 pix=%h",
                         y, ad, nd, first, pm, (y - 50) / 2, exp_mask[(y-50)/2]);
            end
        end
        do_line(66, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 0) begin errors++; $display("FAIL below_sprite: got %0d cycles want 0", nd); end
    endtask

    task automatic test_latch();
        int nd, first, last, stray; logic [15:0] pm; logic [2:0] ad; logic d0;
        do_frame(100, 50);
        for (int y = 50; y <= 54; y++) do_line(y, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        sprx = 16'sd200;
        do_line(55, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (first !== 100 || nd !== 16) begin errors++; $display("FAIL latch_mid_frame: got x0=%0d n=%0d want 100/16", first, nd); end
        for (int y = 56; y <= 66; y++) do_line(y, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        do_frame(200, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (first !== 200 || last !== 215 || nd !== 16) begin errors++; $display("FAIL latch_new_frame: got %0d..%0d n=%0d want 200..215 n=16", first, last, nd); end
    endtask

    task automatic test_edges();
        int nd, first, last, stray, tot; logic [15:0] pm; logic [2:0] ad; logic d0;
        do_frame(-4, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (first !== -4 || last !== 11 || nd !== 16) begin errors++; $display("FAIL neg_x: got %0d..%0d n=%0d want -4..11 n=16", first, last, nd); end
        do_frame(H_STA + 3, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (first !== H_STA + 3 || nd !== 16) begin errors++; $display("FAIL min_x: got x0=%0d n=%0d want %0d n=16", first, nd, H_STA + 3); end
        do_frame(H_STA + 1, 50);
        tot = 0;
        for (int y = 50; y <= 66; y++) begin
            do_line(y, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
            tot += nd;
        end
        checks++; if (tot !== 0) begin errors++; $display("FAIL unreachable_x: got %0d cycles want 0", tot); end
        do_frame(100, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (first !== 100 || nd !== 16) begin errors++; $display("FAIL recover: got x0=%0d n=%0d want 100/16", first, nd); end
    endtask

    task automatic test_frame_line();
        int nd, first, last, stray; logic [15:0] pm; logic [2:0] ad; logic d0;
        sprx = 16'sd100; spry = 16'sd0;
        do_line(0, LINE_LEN, 1'b1, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 16 || first !== 100 || pm !== 16'hC003) begin errors++; $display("FAIL frame_and_line: got n=%0d x0=%0d pix=%h want 16/100/c003", nd, first, pm); end
    endtask

    task automatic test_early_line();
        int nd, first, last, stray; logic [15:0] pm; logic [2:0] ad; logic d0;
        do_frame(100, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        do_line(51, 128, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 8 || last !== 107) begin errors++; $display("FAIL early_cut: got n=%0d last=%0d want 8/107", nd, last); end
        do_line(52, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL early_drop: got drawing=%b want 0", d0); end
        checks++; if (ad !== 3'd1 || nd !== 16 || first !== 100 || pm !== 16'hF00F) begin errors++; $display("FAIL early_next: got addr=%0d n=%0d x0=%0d pix=%h want 1/16/100/f00f", ad, nd, first, pm); end
    endtask

    task automatic test_reset_mid_draw();
        int nd, first, last, stray, after; logic [15:0] pm; logic [2:0] ad; logic d0;
        do_frame(100, 50);
        after = 0;
        for (int i = 0; i < LINE_LEN; i++) begin
            sx = 16'(H_STA + i); sy = 16'sd50; line = (i == 0);
            @(posedge clk); #1;
            if (H_STA + i == 105) begin
                checks++; if (drawing !== 1'b1) begin errors++; $display("FAIL rst_pre: got drawing=%b want 1", drawing); end
                rst_n = 1'b0; #1;
                checks++; if (drawing !== 1'b0 || pix !== 1'b0) begin errors++; $display("FAIL rst_async: got drawing=%b pix=%b want 0/0", drawing, pix); end
                #1 rst_n = 1'b1;
            end else if (H_STA + i > 105 && drawing) begin
                after++;
            end
        end
        line = 1'b0;
        checks++; if (after !== 0) begin errors++; $display("FAIL rst_rest_of_line: got %0d cycles want 0", after); end
        do_line(51, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 0) begin errors++; $display("FAIL rst_next_line: got %0d cycles want 0", nd); end
        do_frame(100, 50);
        do_line(50, LINE_LEN, 1'b0, nd, first, last, pm, ad, d0, stray);
        checks++; if (nd !== 16 || first !== 100) begin errors++; $display("FAIL rst_next_frame: got n=%0d x0=%0d want 16/100", nd, first); end
    endtask

    initial begin
        rom_mem[0] = 8'h81; rom_mem[1] = 8'hC3; rom_mem[2] = 8'hA5; rom_mem[3] = 8'h3C;
        rom_mem[4] = 8'hFF; rom_mem[5] = 8'h18; rom_mem[6] = 8'h7E; rom_mem[7] = 8'h01;
        exp_mask[0] = 16'hC003; exp_mask[1] = 16'hF00F; exp_mask[2] = 16'hCC33; exp_mask[3] = 16'h0FF0;
        exp_mask[4] = 16'hFFFF; exp_mask[5] = 16'h03C0; exp_mask[6] = 16'h3FFC; exp_mask[7] = 16'h0003;
        test_reset();
        test_rows();
        test_latch();
        test_edges();
        test_frame_line();
        test_early_line();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_draw.md
Name: sprite_draw

Overview:
Pixel-stream consumer sitting directly downstream of the 480p display timing generator. Takes its frame/line strobes and registered screen coordinates, then draws one monochrome bitmap sprite at a frame-latched position with integer scaling. Bitmap rows are fetched from a synchronous sprite ROM during horizontal blanking. Output is a 1-bit pixel plus a drawing flag, which the colour/mux stage combines with de.

Parameters:
CORDW, 16, signed coordinate width (matches timing generator)
WIDTH, 8, sprite width in bitmap pixels (= rom_data width)
HEIGHT, 8, sprite height in bitmap rows
SCALE, 2, integer scale factor 1..8 applied in both axes
ADDRW, $clog2(HEIGHT), ROM row address width

Ports:
clk_pix  in  1  pixel clock
rst_n  in  1  reset, asynchronous assert, active-low
frame  in  1  one-cycle strobe at start of frame (sx=H_STA, sy=V_STA)
line  in  1  one-cycle strobe at start of each active line (sx=H_STA, sy>=0)
sx  in  CORDW  signed horizontal position, same cycle as strobes
sy  in  CORDW  signed vertical position
sprx  in  CORDW  signed sprite left edge, sampled only on frame
spry  in  CORDW  signed sprite top edge, sampled only on frame
rom_addr  out  ADDRW  bitmap row index to sprite ROM
rom_data  in  WIDTH  row bitmap; valid exactly 1 cycle after rom_addr changes; MSB = leftmost pixel
pix  out  1  sprite pixel value (registered)
drawing  out  1  high while the current pixel lies inside the sprite box (registered)

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE. rom_addr=0, pix=0, drawing=0. Latched position=0. Row counters=0. Sprite-done flag=1 (nothing drawn until first frame).
- frame=1: latch xl<=sprx and yl<=spry; clear the row counter, scale counter and done flag. sprx/spry changes at any other time are ignored until the next frame.
- Vertical tracking on each line=1 with done=0:
  - Sprite starts when sy==yl; row=0, vsc=0.
  - Each later line: vsc++. When vsc==SCALE-1: vsc=0, row++.
  - After the line with row==HEIGHT-1 and vsc==SCALE-1: set done; no more drawing this frame.
  - No divider is used; row = (sy-yl)/SCALE is produced by these counters.
- FSM states: IDLE, FETCH, LATCH, WAIT_X, DRAW.
  - IDLE: on line with the sprite active on this line -> FETCH, rom_addr<=row. Otherwise stay.
  - FETCH: one cycle for ROM latency -> LATCH.
  - LATCH: shift register <= rom_data, hcnt=0, hsc=0 -> WAIT_X.
  - WAIT_X: when sx==xl -> DRAW, with drawing<=1 and pix<=shreg[WIDTH-1].
  - DRAW: each cycle hsc++. When hsc==SCALE-1: hsc=0, shift left, hcnt++. After WIDTH*SCALE cycles total: drawing<=0, pix<=0 -> IDLE.
- Latency: pix/drawing are registered; the value in cycle t+1 describes input sx in cycle t. drawing is high for exactly WIDTH*SCALE consecutive cycles per sprite line.
- pix=0 whenever drawing=0. Outputs are not gated by de; downstream gates them.
- Horizontal range: xl must be >= H_STA+3 to be reached after the fetch. If xl < H_STA+3, the sprite is not drawn on that line and the FSM returns to IDLE at the next line. Negative xl >= H_STA+3 is drawn during blanking, which is legal.
- If WAIT_X sees sx wrap (a new line strobe) before matching: abort to the line handling below.
- line=1 while in any non-IDLE state: abort current line, drawing<=0, pix<=0, then handle the new line as from IDLE.
- frame and line in the same cycle: frame latch applies first; the line is evaluated against the new yl.
- Width rules: comparisons are signed CORDW. Counters are sized to $clog2(WIDTH*SCALE+1) and $clog2(HEIGHT*SCALE+1).

Test Plan:
1. WIDTH=8, HEIGHT=8, SCALE=2, sprite at (100,50), row0=8'b1000_0001 -> on line sy=50: pix=1 for sx=100,101 and 114,115; pix=0 for sx=102..113; drawing high for sx=100..115 only (16 cycles, 1-cycle delayed).
2. Row mapping: rom_addr=0 for sy=50,51; 1 for 52,53; 7 for 64,65; no FETCH and drawing=0 for sy=49 and sy=66.
3. sprx changed to 200 mid-frame at sy=55 -> drawing stays at sx 100..115 until the next frame strobe, then moves to 200..215.
4. sprx=-4 -> drawing for sx=-4..11, 16 cycles; sprx=H_STA+1 -> no drawing on any line and no hang.
5. rst_n pulsed low mid-DRAW at sx=105 -> pix=0, drawing=0 immediately (async); nothing drawn until after the next frame strobe.
6. Early line strobe injected while in DRAW -> drawing drops next cycle, new row fetched, and the next line draws correctly with the incremented rom_addr.
